uart_tx_core: RTL

Parametrised UART transmit engine for the Avalon UART slave: accepts parallel words over a valid/ready handshake and serialises them LSB-first onto `tx` with start bit, optional parity and 1 or 2 stop bits. A one-word holding register lets back-to-back frames go out with zero idle gap between stop and start. It sits between the Avalon register front-end (TX data register write path) and the pad.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_gen.sv | 38 +++
 rtl/uart_tx_core.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity modes and a parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Unused high bits must be zero; zero-extension leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [8:0] data, input int unsigned mode);
    return (mode == PAR_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
module uart_baud_gen #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = $clog2(CLK_DIV);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_baud_gen: CLK_DIV must be at least 2");
  end

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = !clear && (cnt_q == CntW'(CLK_DIV - 1));

  // Wrap at the bit end; hold at zero while cleared.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmit engine: start bit, LSB-first data, optional parity, 1/2 stop bits,
// with a one-word holding register for gap-free back-to-back frames.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned CLK_DIV   = 16
) (
  input  logic                 tx_clk,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_done,
  output logic                 tx_busy,
  output logic                 tx
);

  localparam int unsigned BitW = $clog2(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_core: DATA_BITS must be 5..9");
  end
  if (PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_core: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_core: STOP_BITS must be 1 or 2");
  end

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 par_q, par_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;

  logic                 bit_tick;
  logic                 accept;
  logic                 frame_end;
  logic                 load_now;
  logic [DATA_BITS-1:0] load_word;

  uart_baud_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk  (tx_clk),
    .rst_n(reset_n),
    .clear(state_q == StIdle),
    .tick (bit_tick)
  );

  assign accept    = tx_valid && !hold_full_q;
  assign frame_end = (state_q == StStop) && bit_tick && (stop_cnt_q == 1'(STOP_BITS - 1));

  // State register.
  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus shifter, holding register and counters.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    par_d       = par_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    done_d      = 1'b0;
    load_now    = 1'b0;
    load_word   = tx_data;

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d  = StStart;
          load_now = 1'b1;
        end
      end
      StStart: begin
        if (bit_tick) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (bit_tick) begin
          if (bit_cnt_q == BitW'(DATA_BITS - 1)) begin
            state_d    = (PARITY == PAR_NONE) ? StStop : StParity;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (bit_tick) begin
          state_d    = StStop;
          stop_cnt_d = 1'b0;
        end
      end
      StStop: begin
        if (frame_end) begin
          done_d = 1'b1;
          if (hold_full_q) begin
            state_d     = StStart;
            load_now    = 1'b1;
            load_word   = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            state_d  = StStart;
            load_now = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (bit_tick) begin
          stop_cnt_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Words accepted mid-frame park in the holding register.
    if (accept && (state_q != StIdle) && !frame_end) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    // Parity is taken from the loaded word, never from the live input.
    if (load_now) begin
      shift_d   = load_word;
      par_d     = parity_bit(9'(load_word), PARITY);
      bit_cnt_d = '0;
    end
  end

  // Line level for the upcoming cycle, derived from next state so tx is a flop.
  always_comb begin
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      par_q       <= par_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign tx_ready = !hold_full_q;
  assign tx_busy  = (state_q != StIdle);

endmodule
